// File: rtl/tiny_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_cpu_pkg
//  Description : Shared constants, state encoding and round-robin helpers
//                for the Tiny-CPU register write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package tiny_cpu_pkg;

  localparam int NREQ   = 3;
  localparam int NREG   = 4;
  localparam int W      = 8;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Rotating-priority pick: scan ptr, ptr+1, ... (mod NREQ), first request wins.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [1:0]      ptr);
    logic [NREQ-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  // One-hot requester vector to index; zero vector maps to 0.
  function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

  // Index to one-hot requester vector.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  // Pointer moves to the requester after the winner, wrapping at NREQ.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick3.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick3
//  Description : Combinational 3-way round-robin selector. Returns the
//                one-hot winner starting the scan at the pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick3
  import tiny_cpu_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  // Winner and a flag saying at least one request was present.
  always_comb begin
    win   = rr_pick(req, ptr);
    valid = |req;
  end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin write scheduler for the 4x8-bit register bank.
//                Grants one write per cycle among three requesters, with
//                locked bursts and a bank-wide clear strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
  import tiny_cpu_pkg::*;
(
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*ADDR_W-1:0] waddr,
  input  logic [NREQ*W-1:0]      wdata,
  input  logic                   clr_req,
  output logic [NREQ-1:0]        gnt,
  output logic [NREG-1:0]        reg_en,
  output logic [W-1:0]           reg_d,
  output logic                   reg_clr,
  output logic                   busy
);

  logic [ADDR_W-1:0] w_addr [NREQ];
  logic [W-1:0]      w_data [NREQ];
  logic [NREQ-1:0]   w_win;
  logic              w_valid;
  logic [1:0]        w_win_idx;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [W-1:0]      r_data;
  logic [NREQ-1:0]   r_gnt;
  logic              r_clr;
  logic              r_busy;

  // Split the packed request buses into per-requester fields.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr[gi] = waddr[gi*ADDR_W +: ADDR_W];
      assign w_data[gi] = wdata[gi*W +: W];
    end
  endgenerate

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .win   (w_win),
    .valid (w_valid)
  );

  assign w_win_idx = onehot_to_idx(w_win);

  // Arbitration FSM: clear first, then the lock owner, then round-robin.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_addr  <= '0;
      r_data  <= '0;
      r_gnt   <= '0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      if (clr_req) begin
        // Clear wins outright and drops any lock; requests wait one edge.
        r_gnt   <= '0;
        r_clr   <= 1'b1;
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else if (r_state == ST_LOCKED) begin
        if (req[r_owner]) begin
          // Owner keeps the path; the pointer is frozen during the burst.
          r_gnt  <= idx_to_onehot(r_owner);
          r_addr <= w_addr[r_owner];
          r_data <= w_data[r_owner];
          if (lock[r_owner]) begin
            r_state <= ST_LOCKED;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_GRANT;
            r_busy  <= 1'b0;
          end
        end else begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      end else if (w_valid) begin
        r_gnt  <= w_win;
        r_addr <= w_addr[w_win_idx];
        r_data <= w_data[w_win_idx];
        r_ptr  <= next_ptr(w_win_idx);
        if (lock[w_win_idx]) begin
          r_state <= ST_LOCKED;
          r_busy  <= 1'b1;
          r_owner <= w_win_idx;
        end else begin
          r_state <= ST_GRANT;
          r_busy  <= 1'b0;
        end
      end else begin
        r_gnt   <= '0;
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  // Enable follows the registered grant so an async reset kills it at once.
  always_comb begin
    reg_en = '0;
    if (|r_gnt) reg_en = NREG'(1) << r_addr;
  end

  assign gnt     = r_gnt;
  assign reg_d   = r_data;
  assign reg_clr = r_clr;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Directed self-checking bench for reg_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  logic        CLK;
  logic        CLR;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [5:0]  waddr;
  logic [23:0] wdata;
  logic        clr_req;
  logic [2:0]  gnt;
  logic [3:0]  reg_en;
  logic [7:0]  reg_d;
  logic        reg_clr;
  logic        busy;

  int total;
  int bad;

  reg_write_arbiter dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .req     (req),
    .lock    (lock),
    .waddr   (waddr),
    .wdata   (wdata),
    .clr_req (clr_req),
    .gnt     (gnt),
    .reg_en  (reg_en),
    .reg_d   (reg_d),
    .reg_clr (reg_clr),
    .busy    (busy)
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] eg, input logic [3:0] ee,
                           input logic [7:0] ed, input logic eb);
    chk({tag, "_gnt"},  {29'd0, gnt},    {29'd0, eg});
    chk({tag, "_en"},   {28'd0, reg_en}, {28'd0, ee});
    chk({tag, "_d"},    {24'd0, reg_d},  {24'd0, ed});
    chk({tag, "_busy"}, {31'd0, busy},   {31'd0, eb});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    CLR     = 1'b0;
    req     = 3'b111;
    lock    = 3'b000;
    clr_req = 1'b0;
    // Requester addresses: r0->2, r1->1, r2->3; data 05 / 11 / 22.
    waddr   = {2'd3, 2'd1, 2'd2};
    wdata   = {8'h22, 8'h11, 8'h05};

    // Reset held across edges with requests pending.
    step();
    step();
    chk_grant("rst", 3'b000, 4'b0000, 8'h00, 1'b0);
    chk("rst_clr", {31'd0, reg_clr}, 32'd0);
    #2 CLR = 1'b1;

    // Fairness with req=111: 001,010,100,001,010,100.
    step(); chk_grant("rr0", 3'b001, 4'b0100, 8'h05, 1'b0);
    step(); chk_grant("rr1", 3'b010, 4'b0010, 8'h11, 1'b0);
    step(); chk_grant("rr2", 3'b100, 4'b1000, 8'h22, 1'b0);
    step(); chk_grant("rr3", 3'b001, 4'b0100, 8'h05, 1'b0);
    step(); chk_grant("rr4", 3'b010, 4'b0010, 8'h11, 1'b0);
    step(); chk_grant("rr5", 3'b100, 4'b1000, 8'h22, 1'b0);

    // Lock burst: pointer is 0, so let requester 1 win alone with lock.
    req  = 3'b010;
    lock = 3'b010;
    step(); chk_grant("lk0", 3'b010, 4'b0010, 8'h11, 1'b1);
    req  = 3'b111;
    step(); chk_grant("lk1", 3'b010, 4'b0010, 8'h11, 1'b1);
    step(); chk_grant("lk2", 3'b010, 4'b0010, 8'h11, 1'b1);
    // Owner grant with lock dropped ends the burst.
    lock = 3'b000;
    step(); chk_grant("lk3", 3'b010, 4'b0010, 8'h11, 1'b0);
    // Pointer stayed at 2 during the burst: requester 2, then 0.
    req  = 3'b101;
    step(); chk_grant("lk4", 3'b100, 4'b1000, 8'h22, 1'b0);
    step(); chk_grant("lk5", 3'b001, 4'b0100, 8'h05, 1'b0);

    // Clear beats a simultaneous request; data holds.
    req     = 3'b001;
    clr_req = 1'b1;
    step();
    chk("clr_strobe", {31'd0, reg_clr}, 32'd1);
    chk_grant("clr", 3'b000, 4'b0000, 8'h05, 1'b0);
    clr_req = 1'b0;
    step();
    chk("clr_after", {31'd0, reg_clr}, 32'd0);
    chk_grant("clr_g", 3'b001, 4'b0100, 8'h05, 1'b0);

    // Idle: no requests, strobes low, data holds.
    req = 3'b000;
    step(); chk_grant("idle", 3'b000, 4'b0000, 8'h05, 1'b0);

    // Async reset in a cycle where gnt=100.
    req = 3'b100;
    step(); chk_grant("ar_pre", 3'b100, 4'b1000, 8'h22, 1'b0);
    #2 CLR = 1'b0;
    #1 chk_grant("ar_mid", 3'b000, 4'b0000, 8'h00, 1'b0);
    #2 CLR = 1'b1;
    req = 3'b111;
    // Pointer back at 0: requester 0 wins despite requester 2 having been last.
    step(); chk_grant("ar_post", 3'b001, 4'b0100, 8'h05, 1'b0);

    // Owner drop: pointer is 1, only requester 2 asks, with lock.
    req  = 3'b100;
    lock = 3'b100;
    step(); chk_grant("od0", 3'b100, 4'b1000, 8'h22, 1'b1);
    req   = 3'b001;
    lock  = 3'b000;
    waddr = {2'd3, 2'd1, 2'd0};
    wdata = {8'h22, 8'h11, 8'hA5};
    step(); chk_grant("od1", 3'b000, 4'b0000, 8'h22, 1'b0);
    step(); chk_grant("od2", 3'b001, 4'b0001, 8'hA5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
